register_bank_param: RTL and testbench

- Parametrised successor to the processor's ID-stage register bank: configurable data width and register count.
- Two registered read ports, one write port, all on a single clock edge, with same-cycle write-to-read bypass.
- Optional hardwired-zero register 0.
- Per-register pending-write scoreboard (busy bits) that the ID stage uses to detect RAW hazards against in-flight instructions.

---
 rtl/regbank_pkg.sv | 19 +
 rtl/regbank_scoreboard.sv | 66 ++++++
 rtl/register_bank_param.sv | 91 +++++++++
 tb/tb_register_bank_param.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regbank_pkg.sv
// Shared register-bank constants and helpers for the ID stage and hazard unit.
// Latency: n/a (package only).
// Backpressure: n/a.
package regbank_pkg;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_NUM_REGS = 8;

    // Ceiling log2, minimum 1 bit so a two-entry bank still has an address bit.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/regbank_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, two registered lookups, OR-reduce.
// Latency: lookups and any_busy registered, 1 cycle, reflecting this cycle's set/clear.
// Backpressure: none; read_en=0 holds busy_a/busy_b, busy vector and any_busy always update.
// Ports: clock/resetN (sync active-low); read_en, addr_a/addr_b lookups;
//        clr_vld/clr_addr (completed write); set_req/set_addr (issue); busy_a/busy_b/any_busy.
module regbank_scoreboard
    import regbank_pkg::*;
#(
    parameter int  NUM_REGS = DEF_NUM_REGS,
    parameter bit  ZERO_REG = 1'b1,
    localparam int ADDR_W   = clog2(NUM_REGS)
) (
    input  logic              clock,
    input  logic              resetN,
    input  logic              read_en,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic              clr_vld,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic              set_req,
    input  logic [ADDR_W-1:0] set_addr,
    output logic              busy_a,
    output logic              busy_b,
    output logic              any_busy
);

    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_nxt;
    logic                set_vld;
    logic                look_a;
    logic                look_b;

    assign set_vld = set_req && (int'(set_addr) < NUM_REGS) && !(ZERO_REG && set_addr == '0);

    // Clear first, then set: an issue in the same cycle as the completing write
    // leaves the register busy because the new producer is still in flight.
    always_comb begin
        busy_nxt = busy;
        if (clr_vld) begin
            busy_nxt[clr_addr] = 1'b0;
        end
        if (set_vld) begin
            busy_nxt[set_addr] = 1'b1;
        end
    end

    assign look_a = (int'(addr_a) < NUM_REGS) ? busy_nxt[addr_a] : 1'b0;
    assign look_b = (int'(addr_b) < NUM_REGS) ? busy_nxt[addr_b] : 1'b0;

    always_ff @(posedge clock) begin
        if (!resetN) begin
            busy     <= '0;
            busy_a   <= 1'b0;
            busy_b   <= 1'b0;
            any_busy <= 1'b0;
        end else begin
            busy     <= busy_nxt;
            any_busy <= |busy_nxt;
            if (read_en) begin
                busy_a <= look_a;
                busy_b <= look_b;
            end
        end
    end

endmodule

// File: rtl/register_bank_param.sv
// Parametrised ID-stage register bank: 2 registered read ports, 1 write port, busy scoreboard.
// Latency: reads 1 cycle, with same-cycle write-to-read bypass on data and busy.
// Backpressure: none; readEn=0 holds read outputs while writes and scoreboard still update.
// Ports: clock/resetN (sync active-low); readEn, readAddrA/B; regWrite, writeAddr, writeData;
//        issueValid, issueAddr; dataA/B, busyA/B, anyBusy (all registered).
module register_bank_param
    import regbank_pkg::*;
#(
    parameter int  DATA_W   = DEF_DATA_W,
    parameter int  NUM_REGS = DEF_NUM_REGS,
    parameter bit  ZERO_REG = 1'b1,
    localparam int ADDR_W   = clog2(NUM_REGS)
) (
    input  logic              clock,
    input  logic              resetN,
    input  logic              readEn,
    input  logic [ADDR_W-1:0] readAddrA,
    input  logic [ADDR_W-1:0] readAddrB,
    input  logic              regWrite,
    input  logic [ADDR_W-1:0] writeAddr,
    input  logic [DATA_W-1:0] writeData,
    input  logic              issueValid,
    input  logic [ADDR_W-1:0] issueAddr,
    output logic [DATA_W-1:0] dataA,
    output logic [DATA_W-1:0] dataB,
    output logic              busyA,
    output logic              busyB,
    output logic              anyBusy
);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              wr_vld;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;

    // A write only counts when it lands on a real, writable register; the same
    // qualified strobe drives the bypass and the scoreboard clear.
    assign wr_vld = regWrite && (int'(writeAddr) < NUM_REGS) && !(ZERO_REG && writeAddr == '0);

    // Out-of-range and hardwired-zero reads return 0 and never see the bypass.
    always_comb begin
        rd_a = '0;
        if ((int'(readAddrA) < NUM_REGS) && !(ZERO_REG && readAddrA == '0)) begin
            rd_a = (wr_vld && writeAddr == readAddrA) ? writeData : regs[readAddrA];
        end
    end

    always_comb begin
        rd_b = '0;
        if ((int'(readAddrB) < NUM_REGS) && !(ZERO_REG && readAddrB == '0)) begin
            rd_b = (wr_vld && writeAddr == readAddrB) ? writeData : regs[readAddrB];
        end
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            dataA <= '0;
            dataB <= '0;
        end else begin
            if (wr_vld) begin
                regs[writeAddr] <= writeData;
            end
            if (readEn) begin
                dataA <= rd_a;
                dataB <= rd_b;
            end
        end
    end

    regbank_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clock    (clock),
        .resetN   (resetN),
        .read_en  (readEn),
        .addr_a   (readAddrA),
        .addr_b   (readAddrB),
        .clr_vld  (wr_vld),
        .clr_addr (writeAddr),
        .set_req  (issueValid),
        .set_addr (issueAddr),
        .busy_a   (busyA),
        .busy_b   (busyB),
        .any_busy (anyBusy)
    );

endmodule

// File: tb/tb_register_bank_param.sv
// Testbench for register_bank_param: default instance (8x16, zero reg) and a 6x32 instance
// without zero reg. Directed table, hand sequences, then randomized traffic vs. a model.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_register_bank_param;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: defaults (DATA_W=16, NUM_REGS=8, ZERO_REG=1)
    logic        r0_rst_n, r0_re, r0_we, r0_iv;
    logic [2:0]  r0_ra, r0_rb, r0_wa, r0_ia;
    logic [15:0] r0_wd;
    logic [15:0] d0_a, d0_b;
    logic        b0_a, b0_b, b0_any;

    // Instance 1: DATA_W=32, NUM_REGS=6, ZERO_REG=0
    logic        r1_rst_n, r1_re, r1_we, r1_iv;
    logic [2:0]  r1_ra, r1_rb, r1_wa, r1_ia;
    logic [31:0] r1_wd;
    logic [31:0] d1_a, d1_b;
    logic        b1_a, b1_b, b1_any;

    register_bank_param dut0 (
        .clock(clk), .resetN(r0_rst_n), .readEn(r0_re),
        .readAddrA(r0_ra), .readAddrB(r0_rb),
        .regWrite(r0_we), .writeAddr(r0_wa), .writeData(r0_wd),
        .issueValid(r0_iv), .issueAddr(r0_ia),
        .dataA(d0_a), .dataB(d0_b), .busyA(b0_a), .busyB(b0_b), .anyBusy(b0_any)
    );

    register_bank_param #(.DATA_W(32), .NUM_REGS(6), .ZERO_REG(1'b0)) dut1 (
        .clock(clk), .resetN(r1_rst_n), .readEn(r1_re),
        .readAddrA(r1_ra), .readAddrB(r1_rb),
        .regWrite(r1_we), .writeAddr(r1_wa), .writeData(r1_wd),
        .issueValid(r1_iv), .issueAddr(r1_ia),
        .dataA(d1_a), .dataB(d1_b), .busyA(b1_a), .busyB(b1_b), .anyBusy(b1_any)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive0(input bit rst, input bit re, input int ra, input int rb, input bit we,
                          input int wa, input logic [31:0] wd, input bit iv, input int ia);
        r0_rst_n = rst; r0_re = re; r0_ra = 3'(ra); r0_rb = 3'(rb);
        r0_we = we; r0_wa = 3'(wa); r0_wd = wd[15:0]; r0_iv = iv; r0_ia = 3'(ia);
    endtask

    task automatic drive1(input bit rst, input bit re, input int ra, input int rb, input bit we,
                          input int wa, input logic [31:0] wd, input bit iv, input int ia);
        r1_rst_n = rst; r1_re = re; r1_ra = 3'(ra); r1_rb = 3'(rb);
        r1_we = we; r1_wa = 3'(wa); r1_wd = wd; r1_iv = iv; r1_ia = 3'(ia);
    endtask

    task automatic chk0(input string tag, input logic [31:0] ea, input logic [31:0] eb,
                        input bit ba, input bit bb, input bit any);
        chk({tag, " i0 dataA"}, 32'(d0_a), ea);
        chk({tag, " i0 dataB"}, 32'(d0_b), eb);
        chk({tag, " i0 busyA"}, 32'(b0_a), 32'(ba));
        chk({tag, " i0 busyB"}, 32'(b0_b), 32'(bb));
        chk({tag, " i0 anyBusy"}, 32'(b0_any), 32'(any));
    endtask

    task automatic chk1(input string tag, input logic [31:0] ea, input logic [31:0] eb,
                        input bit ba, input bit bb, input bit any);
        chk({tag, " i1 dataA"}, d1_a, ea);
        chk({tag, " i1 dataB"}, d1_b, eb);
        chk({tag, " i1 busyA"}, 32'(b1_a), 32'(ba));
        chk({tag, " i1 busyB"}, 32'(b1_b), 32'(bb));
        chk({tag, " i1 anyBusy"}, 32'(b1_any), 32'(any));
    endtask

    // ---------------- directed vector table (instance 0) ----------------
    typedef struct {
        bit          rst_n; bit re; int ra; int rb;
        bit          we; int wa; logic [31:0] wd; bit iv; int ia;
        logic [31:0] ea; logic [31:0] eb; bit eba; bit ebb; bit eany;
    } vec_t;

    localparam int NV = 19;
    vec_t tv [NV];

    function automatic vec_t mk(input bit rst, input bit re, input int ra, input int rb,
                                input bit we, input int wa, input logic [31:0] wd,
                                input bit iv, input int ia, input logic [31:0] ea,
                                input logic [31:0] eb, input bit ba, input bit bb, input bit any);
        vec_t v;
        v.rst_n = rst; v.re = re; v.ra = ra; v.rb = rb; v.we = we; v.wa = wa; v.wd = wd;
        v.iv = iv; v.ia = ia; v.ea = ea; v.eb = eb; v.eba = ba; v.ebb = bb; v.eany = any;
        return v;
    endfunction

    // ---------------- behavioural model (both instances) ----------------
    logic [31:0] m_regs [2][8];
    bit          m_busy [2][8];
    logic [31:0] e_a [2];
    logic [31:0] e_b [2];
    bit          e_ba [2];
    bit          e_bb [2];
    bit          e_any [2];

    // Register file after this cycle's write, busy after clear-then-set, then sample.
    task automatic model_step(input int n, input bit rst, input bit re, input int ra, input int rb,
                              input bit we, input int wa, input logic [31:0] wd,
                              input bit iv, input int ia);
        int          nr;
        bit          z;
        logic [31:0] msk;
        nr  = (n == 0) ? 8 : 6;
        z   = (n == 0);
        msk = (n == 0) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        if (!rst) begin
            for (int i = 0; i < 8; i++) begin
                m_regs[n][i] = '0;
                m_busy[n][i] = 1'b0;
            end
            e_a[n] = '0; e_b[n] = '0; e_ba[n] = 1'b0; e_bb[n] = 1'b0; e_any[n] = 1'b0;
        end else begin
            if (we && wa < nr && !(z && wa == 0)) begin
                m_regs[n][wa] = wd & msk;
                m_busy[n][wa] = 1'b0;
            end
            if (iv && ia < nr && !(z && ia == 0)) m_busy[n][ia] = 1'b1;
            if (re) begin
                e_a[n]  = (ra < nr && !(z && ra == 0)) ? m_regs[n][ra] : 32'h0;
                e_b[n]  = (rb < nr && !(z && rb == 0)) ? m_regs[n][rb] : 32'h0;
                e_ba[n] = (ra < nr) ? m_busy[n][ra] : 1'b0;
                e_bb[n] = (rb < nr) ? m_busy[n][rb] : 1'b0;
            end
            e_any[n] = 1'b0;
            for (int i = 0; i < nr; i++) e_any[n] = e_any[n] | m_busy[n][i];
        end
    endtask

    initial begin
        tv[0]  = mk(0, 1, 3, 4, 1, 3, 32'h1234, 1, 4, 32'h0,    32'h0,    0, 0, 0);
        tv[1]  = mk(1, 1, 3, 4, 0, 0, 32'h0,    0, 0, 32'h0,    32'h0,    0, 0, 0);
        tv[2]  = mk(1, 0, 3, 3, 1, 3, 32'hBEEF, 0, 0, 32'h0,    32'h0,    0, 0, 0);
        tv[3]  = mk(1, 1, 3, 3, 0, 0, 32'h0,    0, 0, 32'hBEEF, 32'hBEEF, 0, 0, 0);
        tv[4]  = mk(1, 0, 3, 3, 1, 5, 32'h1111, 0, 0, 32'hBEEF, 32'hBEEF, 0, 0, 0);
        tv[5]  = mk(1, 1, 5, 3, 1, 5, 32'h2222, 0, 0, 32'h2222, 32'hBEEF, 0, 0, 0);
        tv[6]  = mk(1, 1, 5, 5, 0, 0, 32'h0,    0, 0, 32'h2222, 32'h2222, 0, 0, 0);
        tv[7]  = mk(1, 1, 0, 3, 1, 0, 32'hFFFF, 0, 0, 32'h0,    32'hBEEF, 0, 0, 0);
        tv[8]  = mk(1, 1, 0, 0, 0, 0, 32'h0,    0, 0, 32'h0,    32'h0,    0, 0, 0);
        tv[9]  = mk(1, 1, 0, 0, 0, 0, 32'h0,    1, 0, 32'h0,    32'h0,    0, 0, 0);
        tv[10] = mk(1, 1, 2, 3, 0, 0, 32'h0,    1, 2, 32'h0,    32'hBEEF, 1, 0, 1);
        tv[11] = mk(1, 1, 2, 2, 1, 2, 32'h00AA, 1, 2, 32'h00AA, 32'h00AA, 1, 1, 1);
        tv[12] = mk(1, 1, 2, 5, 1, 2, 32'h00BB, 0, 0, 32'h00BB, 32'h2222, 0, 0, 0);
        tv[13] = mk(1, 0, 6, 6, 0, 0, 32'h0,    1, 6, 32'h00BB, 32'h2222, 0, 0, 1);
        tv[14] = mk(1, 1, 6, 7, 0, 0, 32'h0,    0, 0, 32'h0,    32'h0,    1, 0, 1);
        tv[15] = mk(1, 0, 6, 6, 1, 6, 32'h0C0C, 0, 0, 32'h0,    32'h0,    1, 0, 0);
        tv[16] = mk(1, 1, 6, 6, 0, 0, 32'h0,    0, 0, 32'h0C0C, 32'h0C0C, 0, 0, 0);
        tv[17] = mk(0, 1, 6, 6, 1, 6, 32'hFFFF, 1, 3, 32'h0,    32'h0,    0, 0, 0);
        tv[18] = mk(1, 1, 6, 3, 0, 0, 32'h0,    0, 0, 32'h0,    32'h0,    0, 0, 0);

        // Instance 1 held in reset while the table runs on instance 0.
        drive1(0, 0, 0, 0, 0, 0, 32'h0, 0, 0);
        for (int i = 0; i < NV; i++) begin
            drive0(tv[i].rst_n, tv[i].re, tv[i].ra, tv[i].rb, tv[i].we, tv[i].wa,
                   tv[i].wd, tv[i].iv, tv[i].ia);
            tick();
            chk0($sformatf("vec%0d", i), tv[i].ea, tv[i].eb, tv[i].eba, tv[i].ebb, tv[i].eany);
        end

        // ---------------- instance 1 hand sequences ----------------
        drive0(1, 0, 0, 0, 0, 0, 32'h0, 0, 0);
        drive1(0, 1, 5, 5, 1, 5, 32'h1, 1, 5);
        tick(); chk1("p_reset", 32'h0, 32'h0, 0, 0, 0);
        drive1(1, 1, 7, 6, 1, 7, 32'h7777_7777, 1, 7);
        tick(); chk1("p_wr7", 32'h0, 32'h0, 0, 0, 0);
        drive1(1, 1, 6, 6, 1, 6, 32'h6666_6666, 1, 6);
        tick(); chk1("p_wr6", 32'h0, 32'h0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            drive1(1, 1, i, i, 0, 0, 32'h0, 0, 0);
            tick(); chk1($sformatf("p_untouched%0d", i), 32'h0, 32'h0, 0, 0, 0);
        end
        drive1(1, 0, 0, 0, 1, 5, 32'hDEAD_BEEF, 0, 0);
        tick(); chk1("p_wr5_hold", 32'h0, 32'h0, 0, 0, 0);
        drive1(1, 1, 5, 5, 0, 0, 32'h0, 0, 0);
        tick(); chk1("p_rd5", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 0, 0);
        drive1(1, 1, 0, 5, 1, 0, 32'hA5A5_A5A5, 1, 0);
        tick(); chk1("p_reg0_byp", 32'hA5A5_A5A5, 32'hDEAD_BEEF, 1, 0, 1);
        drive1(1, 1, 0, 0, 1, 0, 32'h5A5A_5A5A, 0, 0);
        tick(); chk1("p_reg0_clr", 32'h5A5A_5A5A, 32'h5A5A_5A5A, 0, 0, 0);

        // ---------------- randomized traffic vs. model ----------------
        for (int k = 0; k < 1500; k++) begin
            for (int n = 0; n < 2; n++) begin
                bit          rst, re, we, iv;
                int          ra, rb, wa, ia;
                logic [31:0] wd;
                rst = (k == 0) ? 1'b0 : ($urandom_range(0, 59) != 0);
                re  = ($urandom_range(0, 3) != 0);
                we  = ($urandom_range(0, 1) != 0);
                iv  = ($urandom_range(0, 2) == 0);
                ra  = $urandom_range(0, 7);
                rb  = $urandom_range(0, 7);
                wa  = $urandom_range(0, 7);
                ia  = $urandom_range(0, 7);
                wd  = $urandom();
                model_step(n, rst, re, ra, rb, we, wa, wd, iv, ia);
                if (n == 0) drive0(rst, re, ra, rb, we, wa, wd, iv, ia);
                else        drive1(rst, re, ra, rb, we, wa, wd, iv, ia);
            end
            tick();
            chk0($sformatf("rnd%0d", k), e_a[0], e_b[0], e_ba[0], e_bb[0], e_any[0]);
            chk1($sformatf("rnd%0d", k), e_a[1], e_b[1], e_ba[1], e_bb[1], e_any[1]);
        end

        // ---------------- reset after activity, then every register reads 0 ----------------
        drive0(0, 1, 2, 3, 1, 2, 32'hFFFF, 1, 2);
        drive1(0, 1, 2, 3, 1, 2, 32'hFFFF_FFFF, 1, 2);
        tick();
        chk0("final_reset", 32'h0, 32'h0, 0, 0, 0);
        chk1("final_reset", 32'h0, 32'h0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            drive0(1, 1, i, 7 - i, 0, 0, 32'h0, 0, 0);
            drive1(1, 1, i, 7 - i, 0, 0, 32'h0, 0, 0);
            tick();
            chk0($sformatf("post_reset_rd%0d", i), 32'h0, 32'h0, 0, 0, 0);
            chk1($sformatf("post_reset_rd%0d", i), 32'h0, 32'h0, 0, 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
